// File: rtl/hw_itr_pkg.sv
// Shared constants and types for the per-core hardware interrupt controller.
package hw_itr_pkg;

  localparam int                ITR_DEF_WARP_CNT      = 4;
  localparam int                ITR_DEF_NW_WIDTH      = 2;
  localparam int                ITR_DEF_NUM_IRQ       = 8;
  localparam int                ITR_DEF_CSR_ADDR_BITS = 12;
  localparam logic [11:0]       ITR_DEF_BASE          = 12'hBC0;
  localparam int                ITR_WIN               = 8;

  localparam logic [2:0] ITR_OFF_IE    = 3'd0;
  localparam logic [2:0] ITR_OFF_IP    = 3'd1;
  localparam logic [2:0] ITR_OFF_CAUSE = 3'd2;
  localparam logic [2:0] ITR_OFF_SWI   = 3'd3;
  localparam logic [2:0] ITR_OFF_EOI   = 3'd4;
  localparam logic [2:0] ITR_OFF_STATE = 3'd5;

  localparam int ITR_SW_CAUSE = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } itr_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    lowest_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_idx = 5'(i);
    end
  endfunction

endpackage

// File: rtl/hw_itr_ctrl_if.sv
// CSR bus from the scalar CSR unit plus the interrupt dispatch handshake to the scheduler.
interface hw_itr_ctrl_if #(
  parameter int NW_WIDTH      = 2,
  parameter int CSR_ADDR_BITS = 12,
  parameter int NUM_IRQ       = 8
);

  logic                      read_enable;
  logic [NW_WIDTH-1:0]       read_wid;
  logic [CSR_ADDR_BITS-1:0]  read_addr;
  logic [3:0][31:0]          read_data;

  logic                      write_enable;
  logic [NW_WIDTH-1:0]       write_wid;
  logic [CSR_ADDR_BITS-1:0]  write_addr;
  logic [3:0][31:0]          write_data;

  logic [NUM_IRQ-1:0]        irq_in;

  logic                      itr_valid;
  logic [NW_WIDTH-1:0]       itr_wid;
  logic [4:0]                itr_cause;
  logic                      itr_ready;

  modport master (
    output read_enable, read_wid, read_addr,
    input  read_data,
    output write_enable, write_wid, write_addr, write_data,
    output irq_in,
    input  itr_valid, itr_wid, itr_cause,
    output itr_ready
  );

  modport slave (
    input  read_enable, read_wid, read_addr,
    output read_data,
    input  write_enable, write_wid, write_addr, write_data,
    input  irq_in,
    output itr_valid, itr_wid, itr_cause,
    input  itr_ready
  );

endinterface

// File: rtl/hw_itr_rr_arb.sv
// Round-robin arbiter over warps in REQ with a registered offer that holds until accepted.
module hw_itr_rr_arb
  import hw_itr_pkg::*;
#(
  parameter int WARP_CNT = ITR_DEF_WARP_CNT,
  parameter int NW_WIDTH = ITR_DEF_NW_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WARP_CNT-1:0] req,
  input  logic [4:0]          req_cause [WARP_CNT],
  input  logic                ready,
  output logic                valid,
  output logic [NW_WIDTH-1:0] wid,
  output logic [4:0]          cause,
  output logic [WARP_CNT-1:0] grant
);

  logic [NW_WIDTH-1:0] ptr;
  logic [NW_WIDTH-1:0] start;
  logic [NW_WIDTH-1:0] pick;
  logic [NW_WIDTH-1:0] idx;
  logic [WARP_CNT-1:0] cand;
  logic                found;
  logic                accept;

  assign accept = valid && ready;

  always_comb begin
    grant = '0;
    if (accept) grant[wid] = 1'b1;
    // The grantee is still in REQ this cycle; keep it from being re-offered.
    cand  = req & ~grant;
    start = accept ? NW_WIDTH'((32'(wid) + 32'd1) % WARP_CNT) : ptr;
    found = 1'b0;
    pick  = start;
    idx   = start;
    for (int i = 0; i < WARP_CNT; i++) begin
      idx = NW_WIDTH'((32'(start) + 32'(i)) % WARP_CNT);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      valid <= 1'b0;
      wid   <= '0;
      cause <= '0;
    end else begin
      if (accept) ptr <= start;
      if (valid && !ready) begin
        // Offer is frozen while waiting; a warp that withdrew costs one idle cycle.
        if (!req[wid]) valid <= 1'b0;
      end else begin
        valid <= found;
        if (found) begin
          wid   <= pick;
          cause <= req_cause[pick];
        end
      end
    end
  end

endmodule

// File: rtl/hw_itr_ctrl.sv
// Per-core interrupt controller: per-warp IE/IP/FSM, IRQ edge detect, CSR window, dispatch.
module hw_itr_ctrl
  import hw_itr_pkg::*;
#(
  parameter int                       WARP_CNT      = ITR_DEF_WARP_CNT,
  parameter int                       NW_WIDTH      = ITR_DEF_NW_WIDTH,
  parameter int                       NUM_IRQ       = ITR_DEF_NUM_IRQ,
  parameter int                       CSR_ADDR_BITS = ITR_DEF_CSR_ADDR_BITS,
  parameter logic [CSR_ADDR_BITS-1:0] ITR_BASE      = CSR_ADDR_BITS'(ITR_DEF_BASE)
) (
  input logic          clk,
  input logic          reset,
  hw_itr_ctrl_if.slave bus
);

  localparam logic [31:0] IRQ_MASK = 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam logic [31:0] REG_MASK = IRQ_MASK | (32'd1 << ITR_SW_CAUSE);

  logic [31:0]         ie        [WARP_CNT];
  logic [31:0]         ip        [WARP_CNT];
  itr_state_t          state     [WARP_CNT];
  logic [31:0]         ip_next   [WARP_CNT];
  logic [31:0]         ip_set    [WARP_CNT];
  logic [31:0]         ip_clr    [WARP_CNT];
  logic [4:0]          cause_vec [WARP_CNT];
  logic [WARP_CNT-1:0] ie_we;
  logic [WARP_CNT-1:0] eoi;
  logic [WARP_CNT-1:0] pend;
  logic [WARP_CNT-1:0] req;
  logic [WARP_CNT-1:0] grant;

  logic [NUM_IRQ-1:0]  irq_q;
  logic                edge_armed;
  logic [31:0]         irq_set;

  logic [CSR_ADDR_BITS-1:0] rd_rel;
  logic [CSR_ADDR_BITS-1:0] wr_rel;
  logic                     rd_hit;
  logic                     wr_hit;
  logic [31:0]              wr_val;
  logic [31:0]              rd_pv;
  logic [31:0]              rdata;

  logic                arb_valid;
  logic [NW_WIDTH-1:0] arb_wid;
  logic [4:0]          arb_cause;

  // Edges are suppressed for the first cycle out of reset so a line held high
  // through reset is taken as the new baseline rather than a fresh request.
  assign irq_set = edge_armed ? 32'(bus.irq_in & ~irq_q) : 32'd0;

  assign rd_rel = bus.read_addr - ITR_BASE;
  assign wr_rel = bus.write_addr - ITR_BASE;
  assign rd_hit = bus.read_enable && (rd_rel < CSR_ADDR_BITS'(ITR_WIN))
               && (32'(bus.read_wid) < 32'(WARP_CNT));
  assign wr_hit = bus.write_enable && (wr_rel < CSR_ADDR_BITS'(ITR_WIN))
               && (32'(bus.write_wid) < 32'(WARP_CNT));
  assign wr_val = bus.write_data[0];

  wire unused_write_lanes = &{1'b0, bus.write_data[3:1]};

  always_comb begin
    for (int w = 0; w < WARP_CNT; w++) begin
      // NOTE: every always_comb output gets a default before any branch; a path
      // that leaves one unassigned would infer a latch.
      ie_we[w]  = 1'b0;
      eoi[w]    = 1'b0;
      ip_set[w] = irq_set;
      ip_clr[w] = '0;
      if (wr_hit && (bus.write_wid == NW_WIDTH'(w))) begin
        case (wr_rel[2:0])
          ITR_OFF_IE:  ie_we[w] = 1'b1;
          ITR_OFF_IP:  ip_clr[w] = wr_val;
          ITR_OFF_SWI: if (wr_val != '0) ip_set[w][ITR_SW_CAUSE] = 1'b1;
          ITR_OFF_EOI: begin
            eoi[w]    = 1'b1;
            ip_clr[w] = 32'd1 << wr_val[4:0];
          end
          default: ;
        endcase
      end
      // Clear is applied first so a simultaneous set survives.
      ip_next[w]   = ((ip[w] & ~ip_clr[w]) | ip_set[w]) & REG_MASK;
      pend[w]      = |(ip[w] & ie[w]);
      req[w]       = (state[w] == REQ);
      cause_vec[w] = lowest_idx(ip[w] & ie[w]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      edge_armed <= 1'b0;
      // NOTE: these per-warp arrays are plain flops, not RAM, so resetting every
      // entry in a loop is legal and required for a defined post-reset state.
      for (int w = 0; w < WARP_CNT; w++) begin
        ie[w]    <= '0;
        ip[w]    <= '0;
        state[w] <= IDLE;
      end
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      irq_q      <= bus.irq_in;
      edge_armed <= 1'b1;
      for (int w = 0; w < WARP_CNT; w++) begin
        if (ie_we[w]) ie[w] <= wr_val & REG_MASK;
        ip[w] <= ip_next[w];
        case (state[w])
          IDLE:    if (pend[w]) state[w] <= REQ;
          REQ: begin
            if (grant[w])      state[w] <= SERVICE;
            else if (!pend[w]) state[w] <= IDLE;
          end
          SERVICE: if (eoi[w]) state[w] <= IDLE;
          default: state[w] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    rd_pv = '0;
    if (rd_hit) begin
      rd_pv = ip[bus.read_wid] & ie[bus.read_wid];
      case (rd_rel[2:0])
        ITR_OFF_IE:    rdata = ie[bus.read_wid];
        ITR_OFF_IP:    rdata = ip[bus.read_wid];
        ITR_OFF_CAUSE: rdata = {|rd_pv, 26'b0, lowest_idx(rd_pv)};
        ITR_OFF_STATE: rdata = {30'b0, state[bus.read_wid]};
        default:       rdata = '0;
      endcase
    end
  end

  assign bus.read_data = {4{rdata}};

  hw_itr_rr_arb #(
    .WARP_CNT (WARP_CNT),
    .NW_WIDTH (NW_WIDTH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_cause (cause_vec),
    .ready     (bus.itr_ready),
    .valid     (arb_valid),
    .wid       (arb_wid),
    .cause     (arb_cause),
    .grant     (grant)
  );

  assign bus.itr_valid = arb_valid;
  assign bus.itr_wid   = arb_wid;
  assign bus.itr_cause = arb_cause;

endmodule
